traffic_phase_sequencer: RTL and testbench

//  Parametrised N-phase traffic light sequencer; generalises the fixed 4-road controller (M1/S/MT/M2).

---
 rtl/traffic_pkg.sv | 19 +
 rtl/traffic_phase_sequencer_if.sv | 23 ++
 rtl/rr_next_phase.sv | 41 ++++
 rtl/traffic_phase_sequencer.sv | 110 +++++++++++
 tb/tb_traffic_phase_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, FSM state type and index-width helper for the traffic phase sequencer.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_e;

  // Phase index width; a single-bit index is kept even for degenerate counts.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Request/lamp bundle between the intersection controller and the phase sequencer.
interface traffic_phase_sequencer_if #(
  parameter int unsigned NUM_PHASES = 4
);
  localparam int unsigned IDX_W = traffic_pkg::idx_width(NUM_PHASES);

  logic [NUM_PHASES-1:0]   demand;
  logic                    force_allred;
  logic [3*NUM_PHASES-1:0] lights;
  logic [IDX_W-1:0]        phase_idx;
  logic [1:0]              state;
  logic                    cycle_start;

  modport master (
    output demand, force_allred,
    input  lights, phase_idx, state, cycle_start
  );

  modport slave (
    input  demand, force_allred,
    output lights, phase_idx, state, cycle_start
  );
endinterface

// File: rtl/rr_next_phase.sv
// Combinational round-robin picker: next phase after cur_idx, optionally skipping idle phases.
module rr_next_phase #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned SKIP_IDLE  = 0
) (
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic [NUM_PHASES-1:0] demand,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  next_valid
);

  logic             found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] pick;
  int unsigned      s;

  // Search cur+1 .. wrap .. cur so the current phase is considered last.
  always_comb begin
    next_idx   = (cur_idx == IDX_W'(NUM_PHASES - 1)) ? '0 : cur_idx + IDX_W'(1);
    next_valid = 1'b1;
    found      = 1'b0;
    cand       = '0;
    pick       = '0;
    s          = 0;
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      s = 32'(cur_idx) + k;
      if (s >= NUM_PHASES) s = s - NUM_PHASES;
      cand = IDX_W'(s);
      if (!found && demand[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    if (SKIP_IDLE != 0) begin
      next_idx   = pick;
      next_valid = found;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-phase traffic light sequencer: GREEN -> YELLOW -> ALL-RED per phase with demand skip and forced all-red.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GREEN_T    = 7,
  parameter int unsigned YELLOW_T   = 3,
  parameter int unsigned ALLRED_T   = 2,
  parameter int unsigned SKIP_IDLE  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_sequencer_if.slave   bus
);

  localparam int unsigned IDX_W = idx_width(NUM_PHASES);
  localparam int unsigned LW    = 3 * NUM_PHASES;
  localparam logic [LW-1:0] ALL_RED = {NUM_PHASES{LIGHT_RED}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic [LW-1:0]    lights_q, lights_d;
  logic             cs_q, cs_d;
  logic [2:0]       slot;
  logic             timer_zero;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_valid;

  rr_next_phase #(
    .NUM_PHASES (NUM_PHASES),
    .IDX_W      (IDX_W),
    .SKIP_IDLE  (SKIP_IDLE)
  ) u_rr (
    .cur_idx    (phase_q),
    .demand     (bus.demand),
    .next_idx   (nxt_idx),
    .next_valid (nxt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ALLRED;
      phase_q  <= IDX_W'(NUM_PHASES - 1);
      timer_q  <= CNT_W'(ALLRED_T - 1);
      lights_q <= ALL_RED;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      lights_q <= lights_d;
      cs_q     <= cs_d;
    end
  end

  // Next state, timer and lamp decode; the timer sits at zero while all-red is held.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    timer_d    = timer_q;
    cs_d       = 1'b0;
    slot       = LIGHT_RED;
    timer_zero = (timer_q == '0);

    case (state_q)
      ST_ALLRED: begin
        if (!timer_zero) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (!bus.force_allred && nxt_valid) begin
          state_d = ST_GREEN;
          phase_d = nxt_idx;
          timer_d = CNT_W'(GREEN_T - 1);
          cs_d    = (nxt_idx == '0);
        end
      end
      ST_GREEN: begin
        if (bus.force_allred || timer_zero) begin
          state_d = ST_YELLOW;
          timer_d = CNT_W'(YELLOW_T - 1);
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_YELLOW: begin
        if (timer_zero) begin
          state_d = ST_ALLRED;
          timer_d = CNT_W'(ALLRED_T - 1);
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ALLRED;
        timer_d = CNT_W'(ALLRED_T - 1);
      end
    endcase

    if (state_d == ST_GREEN)       slot = LIGHT_GREEN;
    else if (state_d == ST_YELLOW) slot = LIGHT_YELLOW;
    lights_d = (ALL_RED & ~(LW'(3'b111) << (3 * phase_d))) | (LW'(slot) << (3 * phase_d));
  end

  assign bus.lights      = lights_q;
  assign bus.phase_idx   = phase_q;
  assign bus.state       = state_q;
  assign bus.cycle_start = cs_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench: three sequencer configurations checked against a cycle model via an expectation queue.
module tb_traffic_phase_sequencer;

  localparam int unsigned NP [3] = '{4, 4, 6};
  localparam int unsigned GT [3] = '{7, 7, 1};
  localparam int unsigned YT [3] = '{3, 3, 1};
  localparam int unsigned AT [3] = '{2, 2, 1};
  localparam int unsigned SK [3] = '{0, 1, 0};

  typedef struct {
    logic [17:0] l;
    logic [2:0]  p;
    logic [1:0]  s;
    logic        c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v [3];
  logic       frc   [3];
  logic [5:0] dem   [3];

  logic [17:0] o_l [3];
  logic [2:0]  o_p [3];
  logic [1:0]  o_s [3];
  logic        o_c [3];

  int   m_st [3];
  int   m_ph [3];
  int   m_age[3];
  logic m_cs [3];

  exp_t sb[$];
  int   cs_at[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t, n, nonred, last_green;
  logic [3:0] seen;
  logic saw_wrap;

  always #5 clk = ~clk;

  traffic_phase_sequencer_if #(.NUM_PHASES(4)) bus0 ();
  traffic_phase_sequencer_if #(.NUM_PHASES(4)) bus1 ();
  traffic_phase_sequencer_if #(.NUM_PHASES(6)) bus2 ();

  assign bus0.demand = dem[0][3:0];
  assign bus1.demand = dem[1][3:0];
  assign bus2.demand = dem[2];
  assign bus0.force_allred = frc[0];
  assign bus1.force_allred = frc[1];
  assign bus2.force_allred = frc[2];

  traffic_phase_sequencer #(.NUM_PHASES(4)) dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(bus0.slave));
  traffic_phase_sequencer #(.NUM_PHASES(4), .SKIP_IDLE(1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(bus1.slave));
  traffic_phase_sequencer #(.NUM_PHASES(6), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1)) dut2 (
    .clk(clk), .rst(rst_v[2]), .bus(bus2.slave));

  always_comb begin
    o_l[0] = 18'(bus0.lights); o_p[0] = 3'(bus0.phase_idx); o_s[0] = bus0.state; o_c[0] = bus0.cycle_start;
    o_l[1] = 18'(bus1.lights); o_p[1] = 3'(bus1.phase_idx); o_s[1] = bus1.state; o_c[1] = bus1.cycle_start;
    o_l[2] = 18'(bus2.lights); o_p[2] = 3'(bus2.phase_idx); o_s[2] = bus2.state; o_c[2] = bus2.cycle_start;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [17:0] exp_lights(int d);
    logic [17:0] r;
    logic [2:0]  c;
    r = '0;
    for (int p = 0; p < int'(NP[d]); p++) begin
      c = 3'b100;
      if (p == m_ph[d]) begin
        if (m_st[d] == 1)      c = 3'b001;
        else if (m_st[d] == 2) c = 3'b010;
      end
      r = r | (18'(c) << (3 * p));
    end
    return r;
  endfunction

  task automatic model_reset(input int d);
    m_st[d] = 0; m_ph[d] = int'(NP[d]) - 1; m_age[d] = 0; m_cs[d] = 1'b0;
  endtask

  // Reference: each state is held for its duration counted in elapsed cycles (age).
  task automatic model_next(input int d);
    int pick, q;
    m_cs[d] = 1'b0;
    pick = -1;
    if (rst_v[d]) begin
      model_reset(d);
    end else if (m_st[d] == 0) begin
      if (m_age[d] < int'(AT[d]) - 1) begin
        m_age[d]++;
      end else if (!frc[d]) begin
        if (SK[d] == 0) begin
          pick = (m_ph[d] + 1) % int'(NP[d]);
        end else begin
          for (int k = 1; k <= int'(NP[d]); k++) begin
            q = (m_ph[d] + k) % int'(NP[d]);
            if (pick < 0 && ((dem[d] >> q) & 6'd1) != 6'd0) pick = q;
          end
        end
        if (pick >= 0) begin
          m_st[d] = 1; m_ph[d] = pick; m_age[d] = 0; m_cs[d] = (pick == 0);
        end
      end
    end else if (m_st[d] == 1) begin
      if (frc[d] || m_age[d] == int'(GT[d]) - 1) begin m_st[d] = 2; m_age[d] = 0; end
      else m_age[d]++;
    end else begin
      if (m_age[d] == int'(YT[d]) - 1) begin m_st[d] = 0; m_age[d] = 0; end
      else m_age[d]++;
    end
  endtask

  task automatic step(input int d);
    exp_t e;
    model_next(d);
    e.l = exp_lights(d);
    e.p = 3'(m_ph[d]);
    e.s = 2'(m_st[d]);
    e.c = m_cs[d];
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("lights", 32'(o_l[d]), 32'(e.l));
    chk("phase_idx", 32'(o_p[d]), 32'(e.p));
    chk("state", 32'(o_s[d]), 32'(e.s));
    chk("cycle_start", 32'(o_c[d]), 32'(e.c));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i] = 1'b1; frc[i] = 1'b0; dem[i] = '0;
      model_reset(i);
    end

    // Reset and start-up of the default configuration
    for (int i = 0; i < 3; i++) step(0);
    chk("t1_reset_lights", 32'(o_l[0]), 32'h924);
    chk("t1_reset_phase", 32'(o_p[0]), 32'd3);
    rst_v[0] = 1'b0;
    step(0);
    chk("t1_still_allred", 32'(o_s[0]), 32'd0);
    step(0);
    chk("t1_first_green", 32'({o_s[0], o_p[0], o_c[0]}), 32'({2'd1, 3'd0, 1'b1}));

    // Free run: cycle_start spacing gives the full rotation period
    t = 2;
    cs_at.push_back(t);
    for (int i = 0; i < 100; i++) begin
      step(0);
      t++;
      if (o_c[0]) cs_at.push_back(t);
    end
    chk("t2_cs_count", 32'(cs_at.size()), 32'd3);
    chk("t2_period", 32'(cs_at[1] - cs_at[0]), 32'd48);

    // Forced all-red from the third green cycle of phase 1
    n = 0;
    while (!(m_st[0] == 1 && m_ph[0] == 1 && m_age[0] == 2) && n < 200) begin step(0); n++; end
    chk("t4_reach_phase1", 32'(n < 200), 32'd1);
    frc[0] = 1'b1;
    step(0);
    chk("t4_yellow_now", 32'({o_s[0], o_p[0]}), 32'({2'd2, 3'd1}));
    for (int i = 0; i < 11; i++) step(0);
    chk("t4_allred_held", 32'(o_s[0]), 32'd0);
    frc[0] = 1'b0;
    step(0);
    chk("t4_phase2_green", 32'({o_s[0], o_p[0]}), 32'({2'd1, 3'd2}));

    // Reset in the middle of phase 2 yellow
    n = 0;
    while (!(m_st[0] == 2 && m_ph[0] == 2 && m_age[0] == 1) && n < 200) begin step(0); n++; end
    chk("t5_reach_yellow2", 32'(n < 200), 32'd1);
    rst_v[0] = 1'b1;
    step(0);
    chk("t5_reset_vals", 32'({o_l[0], o_p[0], o_s[0]}), 32'({18'h924, 3'd3, 2'd0}));
    rst_v[0] = 1'b0;
    step(0);
    step(0);
    chk("t5_restart_green", 32'({o_s[0], o_p[0], o_c[0]}), 32'({2'd1, 3'd0, 1'b1}));
    for (int i = 0; i < 20; i++) step(0);
    rst_v[0] = 1'b1;

    // Demand-actuated skipping
    dem[1] = 6'b000101;
    step(1);
    step(1);
    rst_v[1] = 1'b0;
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (o_s[1] == 2'd1) seen = seen | (4'd1 << o_p[1]);
    end
    chk("t3_only_0_2", 32'(seen), 32'h5);
    dem[1] = '0;
    for (int i = 0; i < 25; i++) step(1);
    chk("t3_idle_hold", 32'(o_s[1]), 32'd0);
    dem[1] = 6'b001000;
    step(1);
    chk("t3_phase3_green", 32'({o_s[1], o_p[1]}), 32'({2'd1, 3'd3}));
    for (int i = 0; i < 10; i++) step(1);
    rst_v[1] = 1'b1;

    // Six phases with single-cycle states
    step(2);
    step(2);
    rst_v[2] = 1'b0;
    saw_wrap = 1'b0;
    last_green = -1;
    for (int i = 0; i < 40; i++) begin
      step(2);
      nonred = 0;
      for (int p = 0; p < 6; p++)
        if (((o_l[2] >> (3 * p)) & 18'h7) != 18'h4) nonred++;
      chk("t6_one_lamp", 32'(nonred <= 1), 32'd1);
      if (o_s[2] == 2'd1) begin
        if (o_p[2] == 3'd0 && last_green == 5) saw_wrap = 1'b1;
        last_green = int'(o_p[2]);
      end
    end
    chk("t6_wrap_5_to_0", 32'(saw_wrap), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
